// File: rtl/apb_requester_pkg.sv
// Shared types for the APB command requester: the transfer FSM state encoding.
package apb_requester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/apb_command_requester_if.sv
// APBv5 bus bundle between a requester and a completer (single-bit user sidebands).
interface apb_command_requester_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    pclk;
    logic                    preset_n;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic                    pwakeup;
    logic                    pauser;
    logic                    pwuser;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport requester (
        output pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb,
               pprot, pwakeup, pauser, pwuser,
        input  prdata, pready, pslverr
    );

    modport completer (
        input  pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb,
               pprot, pwakeup, pauser, pwuser,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_command_requester.sv
// Turns one valid/ready command into one APB setup/access transfer and returns a
// response; a bounded wait-state counter aborts transfers to a hung completer.
module apb_command_requester
    import apb_requester_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output state_e                  dbg_state,
    apb_command_requester_if.requester apb
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // cmd and rsp are valid/ready: a beat moves on a rising edge with both high;
    // rsp_valid and its payload stay put until rsp_ready takes them.
    state_e                  state_q,       state_d;
    logic [CNT_WIDTH-1:0]    cnt_q,         cnt_d;
    logic                    psel_q,        psel_d;
    logic                    penable_q,     penable_d;
    logic                    pwrite_q,      pwrite_d;
    logic                    pwakeup_q,     pwakeup_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,       paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,      pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q,       pstrb_d;
    logic [2:0]              pprot_q,       pprot_d;
    logic                    rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                    rsp_err_q,     rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwakeup_q     <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pwakeup_q     <= pwakeup_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // The current low-pready cycle is the last one allowed; pready still wins it.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && ((int'(cnt_q) + 1) == TIMEOUT_CYCLES);
        state_d     = state_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (apb.pready) begin
                    state_d = RESP;
                end else begin
                    if (timeout_hit) state_d = RESP;
                    if (!(&cnt_q)) cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psel_d        = (state_d == SETUP) || (state_d == ACCESS);
        penable_d     = (state_d == ACCESS);
        pwakeup_d     = psel_d;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        if (state_q == IDLE && cmd_valid) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pprot_d  = cmd_prot;
            pwdata_d = cmd_write ? cmd_wdata : '0;
            pstrb_d  = cmd_write ? cmd_wstrb : '0;
        end

        if (state_q == ACCESS && state_d == RESP) begin
            rsp_valid_d = 1'b1;
            if (apb.pready) begin
                rsp_rdata_d   = pwrite_q ? '0 : apb.prdata;
                rsp_err_d     = apb.pslverr;
                rsp_timeout_d = 1'b0;
            end else begin
                rsp_rdata_d   = '0;
                rsp_err_d     = 1'b1;
                rsp_timeout_d = 1'b1;
            end
        end

        if (state_q == RESP && rsp_ready) begin
            rsp_valid_d   = 1'b0;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b0;
            rsp_timeout_d = 1'b0;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign dbg_state    = state_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_timeout  = rsp_timeout_q;

    assign apb.pclk     = clk;
    assign apb.preset_n = ~rst;
    assign apb.psel     = psel_q;
    assign apb.penable  = penable_q;
    assign apb.pwrite   = pwrite_q;
    assign apb.pwakeup  = pwakeup_q;
    assign apb.paddr    = paddr_q;
    assign apb.pwdata   = pwdata_q;
    assign apb.pstrb    = pstrb_q;
    assign apb.pprot    = pprot_q;
    assign apb.pauser   = 1'b0;
    assign apb.pwuser   = 1'b0;

endmodule
